// File: rtl/div_pkg.sv
// Shared types and helpers for the round-robin sequential divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic dz;
    logic ovf;
  } flags_t;

  // Channel tag width; a single channel still gets a 1-bit tag.
  function automatic int unsigned chw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_core.sv
// Iterative restoring shift-subtract divider with early exit on
// divide-by-zero and quotient overflow. Result ports are valid when done=1.
module div_core
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned QBITS = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz,
  output logic             ovf
);

  localparam int unsigned DW = WIDTH + QBITS;

  logic [WIDTH-1:0] dvd;
  logic [DW-1:0]    dvs;
  logic [QBITS-1:0] mask;
  logic [QBITS-1:0] quo;
  logic             sub;
  logic [WIDTH-1:0] dvd_nx;
  logic [QBITS-1:0] quo_nx;
  flags_t           flg;

  // One restoring step on the current partial remainder
  always_comb begin
    sub    = (dvs <= DW'(dvd));
    dvd_nx = sub ? (dvd - dvs[WIDTH-1:0]) : dvd;
    quo_nx = sub ? (quo | mask) : quo;
  end

  // Classify a new request before committing to the iterative path
  always_comb begin
    flg.dz  = (b == '0);
    flg.ovf = (b != '0) && (DW'(a) >= (DW'(b) << QBITS));
  end

  // Result selection: immediate for flagged requests, last step otherwise
  always_comb begin
    done = 1'b0;
    q    = '0;
    r    = '0;
    dz   = 1'b0;
    ovf  = 1'b0;
    if (start && flg.dz) begin
      done = 1'b1;
      q    = '1;
      r    = a;
      dz   = 1'b1;
    end else if (start && flg.ovf) begin
      done = 1'b1;
      q    = WIDTH'({QBITS{1'b1}});
      r    = a;
      ovf  = 1'b1;
    end else if (busy && mask[0]) begin
      done = 1'b1;
      q    = WIDTH'(quo_nx);
      r    = dvd_nx;
    end
  end

  // Datapath registers and iteration control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      dvd  <= '0;
      dvs  <= '0;
      mask <= '0;
      quo  <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start && !flg.dz && !flg.ovf) begin
      busy <= 1'b1;
      dvd  <= a;
      dvs  <= DW'(b) << (QBITS - 1);
      mask <= QBITS'(1) << (QBITS - 1);
      quo  <= '0;
    end else if (busy) begin
      dvd  <= dvd_nx;
      quo  <= quo_nx;
      dvs  <= dvs >> 1;
      mask <= mask >> 1;
      if (mask[0]) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/rr_seq_divider.sv
// Multi-channel unsigned divider: round-robin arbitration in front of one
// shared iterative core, with a held, backpressured result register.
module rr_seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned QBITS = 15,
  parameter int unsigned NCH   = 2,
  parameter int unsigned CHW   = chw(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [NCH*WIDTH-1:0] in_a,
  input  logic [NCH*WIDTH-1:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CHW-1:0]       out_ch,
  output logic [WIDTH-1:0]     out_q,
  output logic [WIDTH-1:0]     out_r,
  output logic                 out_dz,
  output logic                 out_ovf
);

  state_e           state;
  logic [CHW-1:0]   last_grant;
  logic [CHW-1:0]   grant;
  logic [CHW-1:0]   tag;
  logic             any_req;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             core_busy;
  logic             core_done;
  logic [WIDTH-1:0] core_q;
  logic [WIDTH-1:0] core_r;
  logic             core_dz;
  logic             core_ovf;

  // Round-robin pick, searching from the channel after last_grant
  always_comb begin
    int unsigned    idx;
    logic [CHW-1:0] cidx;
    grant   = last_grant;
    any_req = 1'b0;
    idx     = 0;
    cidx    = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      idx  = (32'(last_grant) + k) % NCH;
      cidx = CHW'(idx);
      if (!any_req && in_valid[cidx]) begin
        any_req = 1'b1;
        grant   = cidx;
      end
    end
  end

  // Accept window and one-hot ready
  always_comb begin
    can_accept = !flush && !core_busy &&
                 ((state == IDLE) || ((state == DONE) && out_ready));
    accept     = can_accept && any_req;
    in_ready   = '0;
    if (accept) in_ready[grant] = 1'b1;
  end

  // Operand mux for the granted channel
  always_comb begin
    sel_a = in_a[32'(grant)*WIDTH +: WIDTH];
    sel_b = in_b[32'(grant)*WIDTH +: WIDTH];
  end

  div_core #(
    .WIDTH (WIDTH),
    .QBITS (QBITS)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .abort (flush),
    .start (accept),
    .a     (sel_a),
    .b     (sel_b),
    .busy  (core_busy),
    .done  (core_done),
    .q     (core_q),
    .r     (core_r),
    .dz    (core_dz),
    .ovf   (core_ovf)
  );

  // Control FSM with arbiter state, channel tag and held result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= CHW'(NCH - 1);
      tag        <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_q      <= '0;
      out_r      <= '0;
      out_dz     <= 1'b0;
      out_ovf    <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= grant;
        tag        <= grant;
      end
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (core_done) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_ch    <= grant;
              out_q     <= core_q;
              out_r     <= core_r;
              out_dz    <= core_dz;
              out_ovf   <= core_ovf;
            end else begin
              state     <= RUN;
              out_valid <= 1'b0;
            end
          end else if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        RUN: begin
          if (core_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_ch    <= tag;
            out_q     <= core_q;
            out_r     <= core_r;
            out_dz    <= core_dz;
            out_ovf   <= core_ovf;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_seq_divider.sv
// Directed bench for rr_seq_divider with an arithmetic reference model.
module tb_rr_seq_divider;

  localparam int unsigned W  = 16;
  localparam int unsigned QB = 15;
  localparam int unsigned N  = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           flush;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_a;
  logic [N*W-1:0] in_b;
  logic           out_valid;
  logic           out_ready;
  logic [0:0]     out_ch;
  logic [W-1:0]   out_q;
  logic [W-1:0]   out_r;
  logic           out_dz;
  logic           out_ovf;

  logic [0:0]     v16;
  logic [0:0]     rdy16;
  logic [W-1:0]   a16;
  logic [W-1:0]   b16;
  logic           ov16;
  logic           ordy16;
  logic [0:0]     ch16;
  logic [W-1:0]   q16;
  logic [W-1:0]   r16;
  logic           dz16;
  logic           ovf16;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  rr_seq_divider #(.WIDTH(W), .QBITS(QB), .NCH(N)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_q(out_q), .out_r(out_r), .out_dz(out_dz), .out_ovf(out_ovf)
  );

  rr_seq_divider #(.WIDTH(W), .QBITS(16), .NCH(1)) u_dut16 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(v16), .in_ready(rdy16), .in_a(a16), .in_b(b16),
    .out_valid(ov16), .out_ready(ordy16), .out_ch(ch16),
    .out_q(q16), .out_r(r16), .out_dz(dz16), .out_ovf(ovf16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [0:0]   ch;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   mlast = N - 1;

  function automatic exp_t model(input logic [0:0] ch, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int now);
    exp_t e;
    e.ch = ch; e.dz = 1'b0; e.ovf = 1'b0;
    if (b == 0) begin
      e.q = 16'hFFFF; e.r = a; e.dz = 1'b1; e.due = now + 1;
    end else if ((int'(a) / int'(b)) >= (1 << QB)) begin
      e.q = W'((1 << QB) - 1); e.r = a; e.ovf = 1'b1; e.due = now + 1;
    end else begin
      e.q = W'(int'(a) / int'(b)); e.r = W'(int'(a) % int'(b)); e.due = now + 1 + QB;
    end
    return e;
  endfunction

  // Compare DUT against the model every cycle, then advance the model
  always @(negedge clk) begin
    logic         exp_v;
    logic         free;
    logic [N-1:0] exp_rdy;
    int           gc;
    if (reset) begin
      sb.delete();
      mlast = N - 1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_q", 32'(out_q), 32'd0);
    end else begin
      exp_v = (sb.size() > 0) && (cyc >= sb[0].due);
      chk("m_out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v) begin
        chk("m_out_ch", 32'(out_ch), 32'(sb[0].ch));
        chk("m_out_q", 32'(out_q), 32'(sb[0].q));
        chk("m_out_r", 32'(out_r), 32'(sb[0].r));
        chk("m_out_dz", 32'(out_dz), 32'(sb[0].dz));
        chk("m_out_ovf", 32'(out_ovf), 32'(sb[0].ovf));
      end
      free    = !flush && ((sb.size() == 0) || (exp_v && out_ready));
      exp_rdy = '0;
      gc      = -1;
      if (free) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (mlast + k) % N;
          if (gc < 0 && in_valid[c]) gc = c;
        end
        if (gc >= 0) exp_rdy[gc] = 1'b1;
      end
      chk("m_in_ready", 32'(in_ready), 32'(exp_rdy));
      if (flush) begin
        sb.delete();
      end else begin
        if (exp_v && out_ready) void'(sb.pop_front());
        if (gc >= 0) begin
          sb.push_back(model(1'(gc), in_a[gc*W +: W], in_b[gc*W +: W], cyc));
          mlast = gc;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    int           ch;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;
    int           lat;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int ch, input logic [W-1:0] a, input logic [W-1:0] b);
    in_a[ch*W +: W] = a;
    in_b[ch*W +: W] = b;
    in_valid[ch]    = 1'b1;
  endtask

  // Returns #1 after the accept edge, with the request withdrawn
  task automatic wait_accept(input int ch);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready[ch] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", 32'(n < 200), 32'd1);
    @(posedge clk); #1;
    in_valid[ch] = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("result_in_time", 32'(edges < 100), 32'd1);
  endtask

  initial begin
    int e;
    int g;
    int t;
    int tprev;
    int n;

    vecs[0] = '{0, 16'hFFFF, 16'd1,     16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 0};
    vecs[1] = '{1, 16'd32768, 16'd1,    16'h7FFF, 16'h8000, 1'b0, 1'b1, 0};
    vecs[2] = '{1, 16'd32767, 16'd1,    16'h7FFF, 16'd0,    1'b0, 1'b0, 15};
    vecs[3] = '{0, 16'd0,     16'd5,    16'd0,    16'd0,    1'b0, 1'b0, 15};
    vecs[4] = '{1, 16'd1,     16'd65535,16'd0,    16'd1,    1'b0, 1'b0, 15};
    vecs[5] = '{0, 16'd65535, 16'd2,    16'd32767,16'd1,    1'b0, 1'b0, 15};
    vecs[6] = '{1, 16'd0,     16'd0,    16'hFFFF, 16'd0,    1'b1, 1'b0, 0};
    vecs[7] = '{0, 16'd50000, 16'd3,    16'd16666,16'd2,    1'b0, 1'b0, 15};

    reset = 1'b1; flush = 1'b0; in_valid = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    v16 = '0; a16 = '0; b16 = '0; ordy16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_ch", 32'(out_ch), 32'd0);
    chk("reset_out_r", 32'(out_r), 32'd0);
    chk("reset_flags", 32'({out_dz, out_ovf}), 32'd0);
    reset = 1'b0;
    in_valid = 2'b10;
    #1;
    chk("ready_follows_valid", 32'(in_ready), 32'b10);
    in_valid = '0;
    tick();

    // Normal division with latency measurement
    set_req(0, 16'd65280, 16'd100);
    wait_accept(0);
    wait_valid(e);
    chk("lat_normal", 32'(e), 32'd15);
    chk("t1_q", 32'(out_q), 32'd652);
    chk("t1_r", 32'(out_r), 32'd80);
    chk("t1_ch", 32'(out_ch), 32'd0);
    chk("t1_flags", 32'({out_dz, out_ovf}), 32'd0);

    // Five-cycle stall with both channels requesting
    set_req(0, 16'd100, 16'd7);
    set_req(1, 16'd16128, 16'd0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_q", 32'(out_q), 32'd652);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("pulse_grant", 32'(in_ready), 32'b10);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid[1] = 1'b0;
    chk("dz_valid_next", 32'(out_valid), 32'd1);
    chk("dz_flag", 32'(out_dz), 32'd1);
    chk("dz_q", 32'(out_q), 32'hFFFF);
    chk("dz_r", 32'(out_r), 32'd16128);
    chk("dz_ch", 32'(out_ch), 32'd1);

    out_ready = 1'b1;
    wait_accept(0);
    wait_valid(e);
    chk("b2b_lat", 32'(e), 32'd15);
    chk("b2b_q", 32'(out_q), 32'd14);
    chk("b2b_r", 32'(out_r), 32'd2);

    // Vector table with out_ready held high
    for (int i = 0; i < 8; i++) begin
      set_req(vecs[i].ch, vecs[i].a, vecs[i].b);
      wait_accept(vecs[i].ch);
      wait_valid(e);
      chk($sformatf("vec%0d_lat", i), 32'(e), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_q", i), 32'(out_q), 32'(vecs[i].q));
      chk($sformatf("vec%0d_r", i), 32'(out_r), 32'(vecs[i].r));
      chk($sformatf("vec%0d_flags", i), 32'({out_dz, out_ovf}), 32'({vecs[i].dz, vecs[i].ovf}));
      chk($sformatf("vec%0d_ch", i), 32'(out_ch), 32'(vecs[i].ch));
    end
    tick();

    // Fairness and throughput after a fresh reset
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    set_req(0, 16'd1000, 16'd10);
    set_req(1, 16'd12345, 16'd123);
    tprev = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      @(negedge clk);
      while (in_ready == '0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("grant_in_time", 32'(n < 100), 32'd1);
      g = in_ready[1] ? 1 : 0;
      chk($sformatf("grant_%0d", k), 32'(g), 32'(k % 2));
      @(posedge clk);
      t = cyc;
      if (k > 0) chk($sformatf("spacing_%0d", k), 32'(t - tprev), 32'(QB + 1));
      tprev = t;
      #1;
    end
    in_valid = '0;
    repeat (20) tick();

    // Flush in the middle of a division
    set_req(1, 16'd5000, 16'd3);
    wait_accept(1);
    repeat (7) tick();
    flush = 1'b1;
    set_req(0, 16'd5000, 16'd3);
    @(negedge clk);
    chk("flush_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("flush_idle_ready", 32'(in_ready), 32'b01);
    wait_accept(0);
    wait_valid(e);
    chk("post_flush_lat", 32'(e), 32'd15);
    chk("post_flush_q", 32'(out_q), 32'd1666);
    chk("post_flush_r", 32'(out_r), 32'd2);
    tick();

    // Asynchronous reset in the middle of a division
    set_req(1, 16'd40000, 16'd7);
    wait_accept(1);
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_q", 32'(out_q), 32'd0);
    chk("async_rst_r", 32'(out_r), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    set_req(0, 16'd300, 16'd7);
    set_req(1, 16'd300, 16'd9);
    @(negedge clk);
    chk("post_rst_grant", 32'(in_ready), 32'b01);
    wait_accept(0);
    in_valid = '0;
    wait_valid(e);
    chk("post_rst_q", 32'(out_q), 32'd42);
    chk("post_rst_r", 32'(out_r), 32'd6);
    repeat (3) tick();

    // Full-width quotient instance
    a16 = 16'hFFFF; b16 = 16'd1; v16 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rdy16[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("q16_accept", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    v16 = 1'b0;
    e = 0;
    while (!ov16 && e < 50) begin
      @(posedge clk); #1;
      e++;
    end
    chk("q16_lat", 32'(e), 32'd16);
    chk("q16_q", 32'(q16), 32'hFFFF);
    chk("q16_r", 32'(r16), 32'd0);
    chk("q16_flags", 32'({dz16, ovf16}), 32'd0);
    chk("q16_ch", 32'(ch16), 32'd0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
